// File: rtl/rom_upload.sv
// rom_upload: serves HPS upload reads (16-bit halfwords) out of SDRAM through a
// one-word buffer, with a speculative fetch of the next word whenever the upper
// half of the buffered word is handed out.
//
// Ports
//   clk_sys, resn            clock, asynchronous active-low reset
//   ioctl_upload/index       upload in progress / target index (filtered by INDEX_MAX)
//   ioctl_rd, ioctl_addr     one-cycle read strobe and halfword byte address
//   ioctl_din, ioctl_wait    registered read data / stall while data not yet valid
//   sdram_raddr/rd_req/ack   toggle handshake towards SDRAM, 32-bit word address
//   sdram_dout               SDRAM data, valid in the cycle the ack matches
//   upload_active            registered upload-select
module rom_upload #(
   parameter logic [24:0] BASE_ADDR = 25'h0000000,
   parameter logic [5:0]  INDEX_MAX = 6'h01
) (
   input  logic        clk_sys,
   input  logic        resn,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_rd,
   input  logic [24:0] ioctl_addr,
   output logic [15:0] ioctl_din,
   output logic        ioctl_wait,
   output logic [24:0] sdram_raddr,
   output logic        sdram_rd_req,
   input  logic        sdram_rd_ack,
   input  logic [31:0] sdram_dout,
   output logic        upload_active
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_PREF  = 2'd2;

   logic [1:0]  r_state;
   logic        r_sel_q;
   logic        r_valid;
   logic [24:0] r_tag;
   logic [31:0] r_data;
   logic        r_discard;
   logic        r_half;
   logic        r_pend;
   logic [24:0] r_pend_word;
   logic        r_pend_half;
   logic [15:0] r_din;
   logic        r_wait;
   logic [24:0] r_raddr;
   logic        r_rd_req;

   logic        w_sel, w_rise, w_fall, w_ack, w_drop, w_rd, w_hit;
   logic [24:0] w_word;
   logic        w_pv;
   logic [24:0] w_pword;
   logic        w_phalf;
   logic        w_unused;

   assign w_sel  = ioctl_upload & (ioctl_index[5:0] <= INDEX_MAX);
   assign w_rise = w_sel & ~r_sel_q;
   assign w_fall = ~w_sel & r_sel_q;
   assign w_word = BASE_ADDR + {ioctl_addr[24:2], 2'b00};
   // Acks are only meaningful while a request is outstanding (any non-idle state).
   assign w_ack  = (r_state != S_IDLE) & (sdram_rd_ack == r_rd_req);
   // Data of a request launched before an upload-select edge belongs to nobody.
   assign w_drop = r_discard | w_rise | w_fall;
   assign w_rd   = ioctl_rd & w_sel & ~r_wait;
   // The buffer is invalidated by a rising select, so never hit in that cycle.
   assign w_hit  = r_valid & ~w_rise & (r_tag == w_word);

   // A read parked behind an outstanding request, or one arriving in its ack cycle.
   assign w_pv    = r_pend | w_rd;
   assign w_pword = r_pend ? r_pend_word : w_word;
   assign w_phalf = r_pend ? r_pend_half : ioctl_addr[1];

   assign w_unused = &{1'b0, ioctl_addr[0], ioctl_index[7:6]};

   always_ff @(posedge clk_sys or negedge resn) begin
      if (!resn) begin
         r_state     <= S_IDLE;
         r_sel_q     <= 1'b0;
         r_valid     <= 1'b0;
         r_tag       <= '0;
         r_data      <= '0;
         r_discard   <= 1'b0;
         r_half      <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_word <= '0;
         r_pend_half <= 1'b0;
         r_din       <= '0;
         r_wait      <= 1'b0;
         r_raddr     <= '0;
         r_rd_req    <= 1'b0;
      end else begin
         r_sel_q <= w_sel;
         if (w_rise) r_valid <= 1'b0;
         // Abort releases the HPS at once; the toggle itself is left to complete.
         if (w_fall) begin
            r_wait <= 1'b0;
            r_pend <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_rd) begin
                  if (w_hit) begin
                     r_din <= ioctl_addr[1] ? r_data[31:16] : r_data[15:0];
                     // Upper half consumed: the HPS will most likely want the next word.
                     if (ioctl_addr[1]) begin
                        r_raddr  <= w_word + 25'd4;
                        r_rd_req <= ~r_rd_req;
                        r_state  <= S_PREF;
                     end
                  end else begin
                     r_wait   <= 1'b1;
                     r_half   <= ioctl_addr[1];
                     r_raddr  <= w_word;
                     r_rd_req <= ~r_rd_req;
                     r_state  <= S_FETCH;
                  end
               end
            end
            default: begin
               if (w_ack) begin
                  r_discard <= 1'b0;
                  r_pend    <= 1'b0;
                  if (w_drop) begin
                     // Stale data: buffer untouched. A read parked meanwhile can only
                     // follow a select rise, so the buffer is invalid -> fetch it.
                     if (w_pv & w_sel) begin
                        r_raddr  <= w_pword;
                        r_rd_req <= ~r_rd_req;
                        r_half   <= w_phalf;
                        r_wait   <= 1'b1;
                        r_state  <= S_FETCH;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_data  <= sdram_dout;
                     r_tag   <= r_raddr;
                     r_valid <= 1'b1;
                     if (r_state == S_FETCH) begin
                        r_din   <= r_half ? sdram_dout[31:16] : sdram_dout[15:0];
                        r_wait  <= 1'b0;
                        r_state <= S_IDLE;
                     end else if (w_pv && (w_pword != r_raddr)) begin
                        r_raddr  <= w_pword;
                        r_rd_req <= ~r_rd_req;
                        r_half   <= w_phalf;
                        r_wait   <= 1'b1;
                        r_state  <= S_FETCH;
                     end else begin
                        if (w_pv) begin
                           r_din  <= w_phalf ? sdram_dout[31:16] : sdram_dout[15:0];
                           r_wait <= 1'b0;
                        end
                        r_state <= S_IDLE;
                     end
                  end
               end else begin
                  if (w_rd) begin
                     r_wait      <= 1'b1;
                     r_pend      <= 1'b1;
                     r_pend_word <= w_word;
                     r_pend_half <= ioctl_addr[1];
                  end
                  if (w_rise | w_fall) r_discard <= 1'b1;
               end
            end
         endcase
      end
   end

   assign ioctl_din     = r_din;
   assign ioctl_wait    = r_wait;
   assign sdram_raddr   = r_raddr;
   assign sdram_rd_req  = r_rd_req;
   assign upload_active = r_sel_q;

endmodule

// File: tb/tb_rom_upload.sv
// Bench for rom_upload: three instances differing only in BASE_ADDR share one
// stimulus stream and one SDRAM ack (their handshakes are identical in timing).
module tb_rom_upload;
   localparam int N = 3;
   localparam logic [N-1:0][24:0] BASES = {25'h1FFFFFC, 25'h0100000, 25'h0000000};

   logic        clk = 1'b0;
   logic        resn, upload, rd, ack, hold;
   logic [7:0]  index;
   logic [24:0] addr;
   logic [15:0] din   [N];
   logic        wt    [N];
   logic [24:0] raddr [N];
   logic        req   [N];
   logic        act   [N];
   logic [31:0] dout  [N];
   int          lat, rcnt;
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   // SDRAM contents: word 0 is the known pattern, everything else derived from the address.
   function automatic logic [31:0] mem(input logic [24:0] a);
      if (a == 25'd0) return 32'hBEEF_CAFE;
      return {~a[15:0], a[15:0] ^ 16'h3C3C};
   endfunction

   function automatic logic [15:0] hsel(input logic [31:0] w, input logic h);
      return h ? w[31:16] : w[15:0];
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      rom_upload #(.BASE_ADDR(BASES[g]), .INDEX_MAX(6'h01)) u_dut (
         .clk_sys(clk), .resn(resn), .ioctl_upload(upload), .ioctl_index(index),
         .ioctl_rd(rd), .ioctl_addr(addr), .ioctl_din(din[g]), .ioctl_wait(wt[g]),
         .sdram_raddr(raddr[g]), .sdram_rd_req(req[g]), .sdram_rd_ack(ack),
         .sdram_dout(dout[g]), .upload_active(act[g]));
      assign dout[g] = mem(raddr[g]);
   end

   // Toggle responder: acks lat cycles after it sees the request, unless held.
   always @(posedge clk or negedge resn) begin
      if (!resn) begin
         ack  <= 1'b0;
         rcnt <= 0;
      end else if (req[0] != ack) begin
         if (!hold && rcnt >= lat - 1) begin
            ack  <= req[0];
            rcnt <= 0;
         end else begin
            rcnt <= rcnt + 1;
         end
      end else begin
         rcnt <= 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rd(input logic [24:0] a);
      rd   = 1'b1;
      addr = a;
      tick();
      rd   = 1'b0;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (wt[0] && n < 100) begin
         tick();
         n++;
      end
      chk({nm, "_ready"}, 32'(wt[0]), 0);
   endtask

   task automatic settle();
      int n = 0;
      while (req[0] != ack && n < 100) begin
         tick();
         n++;
      end
      tick();
   endtask

   // ---------------- reference model / per-cycle compare ----------------
   // Model view: the block holds the most recently delivered SDRAM word. With no
   // request outstanding, a read of that word is a 1-cycle hit (upper half also
   // launches a fetch of the next word); any other read is a miss that fetches it.
   // Every served read must return the SDRAM halfword at BASE + address.
   logic        mon_en = 1'b0;
   logic        mbv, p_out, last_req, owed, ow_half, ex_half, ex_req;
   logic [24:0] mbw, p_rw, ow_word, ex_word;
   int          exp_kind, owed_cyc;

   always @(negedge clk) begin
      logic        ack_now, cur_out;
      logic [24:0] wa;
      if (mon_en) begin
         ack_now = p_out && (req[0] == ack);
         cur_out = (req[0] != ack);
         if (ack_now) begin
            mbv = 1'b1;
            mbw = p_rw;
         end
         if (req[0] != last_req) begin
            chk("req_while_busy", 32'(p_out), 0);
            chk("raddr_align", 32'(raddr[0][1:0]), 0);
            p_rw     = raddr[0];
            last_req = req[0];
         end
         if (exp_kind == 1) begin
            chk("hit_wait", 32'(wt[0]), 0);
            if (ex_half) begin
               chk("pf_toggle", 32'(req[0] ^ ex_req), 1);
               chk("pf_addr", 32'(raddr[0]), 32'(ex_word) + 4);
            end else begin
               chk("hit_no_req", 32'(req[0] ^ ex_req), 0);
            end
         end else if (exp_kind == 2) begin
            chk("miss_wait", 32'(wt[0]), 1);
            chk("miss_toggle", 32'(req[0] ^ ex_req), 1);
            chk("miss_addr", 32'(raddr[0]), 32'(ex_word));
         end
         exp_kind = 0;
         if (owed) begin
            if (!wt[0]) begin
               for (int k = 0; k < N; k++) begin
                  wa = BASES[k] + ow_word;
                  chk($sformatf("data%0d", k), 32'(din[k]), 32'(hsel(mem(wa), ow_half)));
               end
               owed = 1'b0;
            end else begin
               owed_cyc++;
               if (owed_cyc > 100) begin
                  chk("owed_timeout", 32'(wt[0]), 0);
                  owed = 1'b0;
               end
            end
         end
         if (rd && !wt[0]) begin
            owed     = 1'b1;
            owed_cyc = 0;
            ow_word  = {addr[24:2], 2'b00};
            ow_half  = addr[1];
            if (!cur_out && !ack_now) begin
               ex_word  = ow_word;
               ex_half  = ow_half;
               ex_req   = req[0];
               exp_kind = (mbv && mbw == ow_word) ? 1 : 2;
            end
         end
         p_out = cur_out;
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      resn = 1'b0; upload = 1'b0; rd = 1'b0; index = 8'd1; addr = '0;
      hold = 1'b0; lat = 3;
      #1;
      chk("rst_din", 32'(din[0]), 0);
      chk("rst_wait", 32'(wt[0]), 0);
      chk("rst_raddr", 32'(raddr[0]), 0);
      chk("rst_req", 32'(req[0]), 0);
      chk("rst_active", 32'(act[0]), 0);
      tick();
      resn = 1'b1; upload = 1'b1;
      tick(); tick();
      chk("active", 32'(act[0]), 1);

      // cold miss
      pulse_rd(25'h000);
      chk("cold_wait", 32'(wt[0]), 1);
      chk("cold_req", 32'(req[0]), 1);
      chk("cold_raddr", 32'(raddr[0]), 0);
      tick(); tick(); tick();
      chk("cold_wait_ackcyc", 32'(wt[0]), 1);
      tick();
      chk("cold_wait_done", 32'(wt[0]), 0);
      chk("cold_din", 32'(din[0]), 32'hCAFE);

      // hit on upper half launches prefetch of the next word
      pulse_rd(25'h002);
      chk("hit_din", 32'(din[0]), 32'hBEEF);
      chk("hit_wait0", 32'(wt[0]), 0);
      chk("pf_req", 32'(req[0]), 0);
      chk("pf_raddr", 32'(raddr[0]), 25'h004);
      settle();
      pulse_rd(25'h004);
      chk("pf_hit_wait", 32'(wt[0]), 0);
      chk("pf_hit_din", 32'(din[0]), 32'h3C38);
      chk("pf_hit_noreq", 32'(req[0]), 0);

      // collision with an outstanding prefetch of the same word
      pulse_rd(25'h000);
      wait_ready("c0");
      pulse_rd(25'h002);
      pulse_rd(25'h004);
      chk("coll_wait", 32'(wt[0]), 1);
      wait_ready("coll");
      chk("coll_din", 32'(din[0]), 32'h3C38);
      chk("coll_noreq", 32'(req[0]), 0);
      // read of another word during a prefetch: demand fetch after the prefetch ack
      pulse_rd(25'h006);
      chk("pf2_din", 32'(din[0]), 32'hFFFB);
      pulse_rd(25'h100);
      chk("coll2_wait", 32'(wt[0]), 1);
      wait_ready("coll2");
      chk("coll2_raddr", 32'(raddr[0]), 25'h100);
      chk("coll2_din", 32'(din[0]), 32'h3D3C);
      chk("coll2_req", 32'(req[0]), 0);

      // index filter
      index = 8'd2;
      tick(); tick();
      pulse_rd(25'h040);
      chk("filt_wait", 32'(wt[0]), 0);
      chk("filt_req", 32'(req[0]), 0);
      index = 8'd1;
      tick(); tick();
      // offset and wrap-around
      pulse_rd(25'h006);
      chk("ofs_wait", 32'(wt[0]), 1);
      chk("ofs_raddr1", 32'(raddr[1]), 25'h100004);
      chk("wrap_raddr2", 32'(raddr[2]), 25'h0000000);
      wait_ready("ofs");
      chk("ofs_din1", 32'(din[1]), 32'hFFFB);
      chk("wrap_din2", 32'(din[2]), 32'hBEEF);

      // abort during a fetch
      hold = 1'b1;
      pulse_rd(25'h040);
      upload = 1'b0;
      tick();
      chk("abort_wait", 32'(wt[0]), 0);
      chk("abort_active", 32'(act[0]), 0);
      hold = 1'b0;
      settle();
      tick();
      chk("abort_din_kept", 32'(din[0]), 32'hFFFB);
      chk("abort_noreq", 32'(req[0]), 0);
      upload = 1'b1;
      tick(); tick();
      pulse_rd(25'h000);
      chk("reup_miss", 32'(wt[0]), 1);
      wait_ready("reup");
      chk("reup_din", 32'(din[0]), 32'hCAFE);

      // reset in the middle of a fetch
      hold = 1'b1;
      pulse_rd(25'h080);
      #2 resn = 1'b0;
      #1;
      chk("mrst_din", 32'(din[0]), 0);
      chk("mrst_wait", 32'(wt[0]), 0);
      chk("mrst_raddr", 32'(raddr[0]), 0);
      chk("mrst_req", 32'(req[0]), 0);
      chk("mrst_active", 32'(act[0]), 0);
      hold = 1'b0;
      tick();
      resn = 1'b1;
      tick(); tick();
      pulse_rd(25'h000);
      chk("post_rst_req", 32'(req[0]), 1);
      chk("post_rst_wait", 32'(wt[0]), 1);
      wait_ready("post_rst");
      chk("post_rst_din", 32'(din[0]), 32'hCAFE);

      // random phase: re-arm select so the buffer starts empty, then free-run
      index = 8'd2;
      tick(); tick(); tick();
      index = 8'd1;
      tick(); tick();
      mbv = 1'b0; mbw = '0; p_out = 1'b0; p_rw = '0; last_req = req[0];
      owed = 1'b0; owed_cyc = 0; exp_kind = 0;
      mon_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         lat = int'($urandom_range(1, 4));
         repeat ($urandom_range(0, 2)) tick();
         wait_ready("rnd");
         pulse_rd(25'($urandom_range(0, 31) * 2));
      end
      wait_ready("rnd_end");
      settle();
      tick();
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
